bus_ram: RTL and testbench

BUS_RAM -- requirements
Module: bus_ram

---
 rtl/bus_ram_pkg.sv | 16 +
 rtl/bus_ram_array.sv | 45 ++++
 rtl/bus_ram.sv | 135 +++++++++++++
 tb/tb_bus_ram.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ram_pkg.sv
// Shared constants and FSM state encoding for the bus-attached RAM.
package bus_ram_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_WAIT   = 0;
    localparam int WCNT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_CLEAR  = 2'd3
    } state_e;

endpackage

// File: rtl/bus_ram_array.sv
// Word storage with byte-lane write enables and a registered read port.
module bus_ram_array
    import bus_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_ram.sv
// Bus-facing RAM controller: request latching, wait states, array clear and ack.
module bus_ram
    import bus_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WAIT   = DEF_WAIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clr,
    output logic [DATA_W-1:0]   dout,
    output logic                ack,
    output logic                busy
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD = (WAIT > 0) ? WCNT_W'(WAIT - 1) : '0;

    state_e                state_q;
    logic [WCNT_W-1:0]     wcnt_q;
    logic [ADDR_W-1:0]     ccnt_q;
    logic                  ack_q;
    logic                  lat_we_q;
    logic [ADDR_W-1:0]     lat_addr_q;
    logic [DATA_W-1:0]     lat_din_q;
    logic [DATA_W/8-1:0]   lat_be_q;

    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            ccnt_q     <= '0;
            ack_q      <= 1'b0;
            lat_we_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_din_q  <= '0;
            lat_be_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clr) begin
                        state_q <= S_CLEAR;
                        ccnt_q  <= '0;
                    end else if (cs && req) begin
                        lat_we_q   <= we;
                        lat_addr_q <= addr;
                        lat_din_q  <= din;
                        lat_be_q   <= be;
                        if (WAIT > 0) begin
                            state_q <= S_WAIT;
                            wcnt_q  <= WAIT_LOAD;
                        end else begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == '0) begin
                        state_q <= S_ACCESS;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                S_ACCESS: begin
                    ack_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_CLEAR: begin
                    if (ccnt_q == '1) begin
                        ccnt_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        ccnt_q <= ccnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Reset blocks the array port so an aborted access or clear leaves memory untouched.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = lat_addr_q;
        mem_wdata = lat_din_q;
        mem_be    = lat_be_q;
        if (!rst) begin
            case (state_q)
                S_ACCESS: begin
                    mem_we = lat_we_q;
                    mem_re = !lat_we_q;
                end
                S_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_addr  = ccnt_q;
                    mem_wdata = '0;
                    mem_be    = '1;
                end
                default: ;
            endcase
        end
    end

    bus_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .be_i    (mem_be),
        .rdata_o (dout)
    );

    assign ack  = ack_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_ram.sv
// Randomized scoreboard bench for bus_ram, run on a WAIT=0 and a WAIT=3 instance in parallel.
module tb_bus_ram;

    logic        clk = 1'b0;
    logic        rst_s  [2];
    logic        cs_s   [2];
    logic        req_s  [2];
    logic        we_s   [2];
    logic [7:0]  addr_s [2];
    logic [15:0] din_s  [2];
    logic [1:0]  be_s   [2];
    logic        clr_s  [2];
    logic [15:0] dout_s [2];
    logic        ack_s  [2];
    logic        busy_s [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] mm [2][256];
    logic [15:0] model_dout [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_ram #(
            .DATA_W (16),
            .ADDR_W (8),
            .WAIT   (g == 0 ? 0 : 3)
        ) dut (
            .clk  (clk),
            .rst  (rst_s[g]),
            .cs   (cs_s[g]),
            .req  (req_s[g]),
            .we   (we_s[g]),
            .addr (addr_s[g]),
            .din  (din_s[g]),
            .be   (be_s[g]),
            .clr  (clr_s[g]),
            .dout (dout_s[g]),
            .ack  (ack_s[g]),
            .busy (busy_s[g])
        );
    end

    function automatic int wlat(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    function automatic void push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation in cycle and data.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack_s[d] === 1'b1) begin
                if (qsize(d) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack dut%0d cyc=%0d: got ack=1 expected ack=0", d, cyc);
                end else begin
                    exp_t e;
                    e = qfront(d);
                    qpop(d);
                    chk("ack_cycle", d, 32'(cyc), 32'(e.due));
                    chk("dout", d, {16'h0, dout_s[d]}, {16'h0, e.data});
                end
            end else if (qsize(d) > 0 && qfront(d).due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_ack dut%0d cyc=%0d: got ack=0 expected ack=1 (due %0d)",
                         d, cyc, qfront(d).due);
                qpop(d);
            end
        end
    end

    // Issue n accesses with req held high; called and returns at a falling edge.
    task automatic burst(input int d, input logic w, input logic [7:0] a, input logic [15:0] data,
                         input logic [1:0] b, input int n);
        int          acc;
        exp_t        e;
        logic [15:0] word;
        cs_s[d] = 1'b1; req_s[d] = 1'b1; we_s[d] = w;
        addr_s[d] = a; din_s[d] = data; be_s[d] = b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            acc = cyc;
            if (w) begin
                word = mm[d][a];
                for (int l = 0; l < 2; l++) begin
                    if (b[l]) word[8*l +: 8] = data[8*l +: 8];
                end
                mm[d][a] = word;
            end else begin
                model_dout[d] = mm[d][a];
            end
            e.due  = acc + wlat(d) + 1;
            e.data = model_dout[d];
            push(d, e);
            if (i < n - 1) repeat (wlat(d) + 1) @(posedge clk);
        end
        @(negedge clk);
        req_s[d] = 1'b0; cs_s[d] = 1'($urandom_range(0, 1));
        for (int k = 0; k <= wlat(d); k++) begin
            if (k > 0) @(negedge clk);
            chk("busy_during", d, {31'h0, busy_s[d]}, 32'h1);
        end
        @(negedge clk);
        chk("busy_after", d, {31'h0, busy_s[d]}, 32'h0);
    endtask

    task automatic idle_gap(input int d);
        cs_s[d] = 1'b0; req_s[d] = 1'b1; we_s[d] = 1'b1;
        repeat (2) @(negedge clk);
        chk("cs0_idle", d, {31'h0, busy_s[d]}, 32'h0);
        cs_s[d] = 1'b1; req_s[d] = 1'b0;
        @(negedge clk);
        chk("req0_idle", d, {31'h0, busy_s[d]}, 32'h0);
        cs_s[d] = 1'b0;
    endtask

    // clr together with a write request; the request must be dropped.
    task automatic do_clear(input int d, input bit partial);
        clr_s[d] = 1'b1; cs_s[d] = 1'b1; req_s[d] = 1'b1; we_s[d] = 1'b1;
        addr_s[d] = 8'h44; din_s[d] = 16'hDEAD; be_s[d] = 2'b11;
        @(posedge clk); #1;
        clr_s[d] = 1'b0; req_s[d] = 1'b0;
        if (!partial) begin
            for (int k = 0; k < 256; k++) mm[d][k] = 16'h0;
            repeat (100) @(negedge clk);
            clr_s[d] = 1'b1;
            @(negedge clk);
            clr_s[d] = 1'b0;
            repeat (155) @(negedge clk);
            chk("clear_busy_last", d, {31'h0, busy_s[d]}, 32'h1);
            @(negedge clk);
            chk("clear_done", d, {31'h0, busy_s[d]}, 32'h0);
        end else begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            rst_s[d] = 1'b1;
            @(negedge clk);
            rst_s[d] = 1'b0;
            for (int k = 0; k < 10; k++) mm[d][k] = 16'h0;
            model_dout[d] = 16'h0;
            chk("pclr_dout", d, {16'h0, dout_s[d]}, 32'h0);
            chk("pclr_busy", d, {31'h0, busy_s[d]}, 32'h0);
        end
    endtask

    // Write accepted then reset before it completes: no ack, memory unchanged.
    task automatic abort_write(input int d, input logic [7:0] a, input logic [15:0] data);
        cs_s[d] = 1'b1; req_s[d] = 1'b1; we_s[d] = 1'b1;
        addr_s[d] = a; din_s[d] = data; be_s[d] = 2'b11;
        @(posedge clk); #1;
        req_s[d] = 1'b0;
        @(negedge clk);
        rst_s[d] = 1'b1;
        @(negedge clk);
        rst_s[d] = 1'b0;
        model_dout[d] = 16'h0;
        chk("abort_dout", d, {16'h0, dout_s[d]}, 32'h0);
        chk("abort_busy", d, {31'h0, busy_s[d]}, 32'h0);
    endtask

    task automatic run_seq(input int d);
        logic [7:0] a;
        do_clear(d, 1'b0);
        burst(d, 1'b0, 8'h00, 16'h0, 2'b11, 1);
        burst(d, 1'b0, 8'hFF, 16'h0, 2'b11, 1);
        burst(d, 1'b1, 8'h10, 16'hBEEF, 2'b11, 1);
        burst(d, 1'b0, 8'h10, 16'h0, 2'b00, 1);
        burst(d, 1'b1, 8'h20, 16'h1234, 2'b11, 1);
        burst(d, 1'b1, 8'h20, 16'hABCD, 2'b01, 1);
        burst(d, 1'b0, 8'h20, 16'h0, 2'b11, 1);
        burst(d, 1'b1, 8'h20, 16'hFFFF, 2'b00, 1);
        burst(d, 1'b0, 8'h20, 16'h0, 2'b11, 1);
        burst(d, 1'b1, 8'h30, 16'h5555, 2'b11, 1);
        abort_write(d, 8'h30, 16'hAAAA);
        burst(d, 1'b0, 8'h30, 16'h0, 2'b11, 1);
        burst(d, 1'b0, 8'h20, 16'h0, 2'b11, 4);
        idle_gap(d);
        burst(d, 1'b1, 8'h00, 16'h1111, 2'b11, 1);
        burst(d, 1'b1, 8'hFF, 16'h2222, 2'b11, 1);
        do_clear(d, 1'b0);
        burst(d, 1'b0, 8'h00, 16'h0, 2'b11, 1);
        burst(d, 1'b0, 8'hFF, 16'h0, 2'b11, 1);
        burst(d, 1'b1, 8'h09, 16'h9999, 2'b11, 1);
        burst(d, 1'b1, 8'h0A, 16'h7777, 2'b11, 1);
        burst(d, 1'b1, 8'h80, 16'h8888, 2'b11, 1);
        do_clear(d, 1'b1);
        burst(d, 1'b0, 8'h09, 16'h0, 2'b11, 1);
        burst(d, 1'b0, 8'h0A, 16'h0, 2'b11, 1);
        burst(d, 1'b0, 8'h80, 16'h0, 2'b11, 1);
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) idle_gap(d);
            else burst(d, 1'($urandom_range(0, 1)), a, 16'($urandom),
                       2'($urandom_range(0, 3)), $urandom_range(1, 3));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; cs_s[d] = 1'b0; req_s[d] = 1'b0; we_s[d] = 1'b0;
            addr_s[d] = 8'h0; din_s[d] = 16'h0; be_s[d] = 2'b00; clr_s[d] = 1'b0;
            model_dout[d] = 16'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_dout", d, {16'h0, dout_s[d]}, 32'h0);
            chk("rst_ack", d, {31'h0, ack_s[d]}, 32'h0);
            chk("rst_busy", d, {31'h0, busy_s[d]}, 32'h0);
            rst_s[d] = 1'b0;
        end
        fork
            run_seq(0);
            run_seq(1);
        join
        repeat (8) @(negedge clk);
        chk("sb_empty", 0, 32'(q0.size()), 32'h0);
        chk("sb_empty", 1, 32'(q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
